apb_completer_regs: RTL

APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

---
 rtl/apb_completer_regs_pkg.sv | 18 +
 rtl/apb_completer_regs_wait_counter.sv | 29 ++
 rtl/apb_completer_regs.sv | 130 +++++++++++++
 3 files changed

// File: rtl/apb_completer_regs_pkg.sv
// Shared APB definitions: transfer-state encoding, register offsets and map size.
// Used by both the APB initiator and the completer register block.
package apb_completer_regs_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam logic [3:0] OFF_REG0 = 4'h0;
    localparam logic [3:0] OFF_REG1 = 4'h4;
    localparam logic [3:0] OFF_REG2 = 4'h8;
    localparam logic [3:0] OFF_WCNT = 4'hC;

    localparam int NUM_REGS = 4;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/apb_completer_regs_wait_counter.sv
// Access-phase wait-state counter: loaded at setup, counts down to zero, then holds.
module apb_wait_counter
    import apb_completer_regs_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with three R/W registers and a read-only count of committed writes.
// Responses (pready/pslverr/prdata) are combinational from the ACCESS state and wait counter.
module apb_completer_regs
    import apb_completer_regs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hA000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

    apb_state_e  r_state;
    apb_state_e  w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_regs [NUM_REGS-1];
    logic [31:0] r_wcnt;

    logic        w_setup;
    logic        w_dec;
    logic        w_done;
    logic        w_zero;
    logic [31:0] w_off;
    logic        w_err;
    logic        w_commit;
    logic [31:0] w_rd_reg;

    apb_wait_counter #(.W(WAIT_W)) u_wait (
        .clk        (pclk),
        .rst        (preset),
        .i_load     (w_setup),
        .i_load_val (WAIT_LD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A missing setup (penable already high in IDLE) never starts a transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_setup     = 1'b0;
        w_dec       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_setup     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_zero) begin
                    w_dec = 1'b1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (w_setup) begin
            r_addr  <= paddr;
            r_wdata <= pwdata;
            r_write <= pwrite;
        end
    end

    // Unsigned offset wraps for addresses below BASE_ADDR, so one compare covers both ends.
    assign w_off    = r_addr - BASE_ADDR;
    assign w_err    = (w_off[31:4] != '0) || (r_addr[1:0] != 2'b00) ||
                      (r_write && (w_off[3:0] == OFF_WCNT));
    assign w_commit = w_done && !w_err && r_write;

    always_comb begin
        w_rd_reg = '0;
        case (w_off[3:0])
            OFF_REG0: w_rd_reg = r_regs[0];
            OFF_REG1: w_rd_reg = r_regs[1];
            OFF_REG2: w_rd_reg = r_regs[2];
            OFF_WCNT: w_rd_reg = r_wcnt;
            default:  w_rd_reg = '0;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                r_regs[i] <= '0;
            end
            r_wcnt <= '0;
        end else if (w_commit) begin
            case (w_off[3:0])
                OFF_REG0: r_regs[0] <= r_wdata;
                OFF_REG1: r_regs[1] <= r_wdata;
                OFF_REG2: r_regs[2] <= r_wdata;
                default:  ;
            endcase
            r_wcnt <= r_wcnt + 32'd1;
        end
    end

    assign pready  = w_done;
    assign pslverr = w_done && w_err;
    assign prdata  = (w_done && !w_err && !r_write) ? w_rd_reg : 32'h0;

endmodule
